// File: rtl/clk_counter_leds_pkg.sv
// Shared widths and types for the DE0-Nano LED counter demo.
package clk_counter_leds_pkg;

  localparam int unsigned COUNTER_W       = 32;
  localparam int unsigned LED_W           = 8;
  localparam int unsigned LED_LSB         = COUNTER_W - LED_W;
  localparam int unsigned RST_SYNC_STAGES = 2;

  typedef logic [COUNTER_W-1:0] counter_t;
  typedef logic [LED_W-1:0]     leds_t;

  // Top byte of the counter, shown on the LEDs.
  function automatic leds_t led_field(input counter_t cnt);
    return cnt[COUNTER_W-1:LED_LSB];
  endfunction

endpackage

// File: rtl/clk_counter_leds_reset_sync.sv
// Active-low reset synchronizer: asserts asynchronously, releases after Stages clock edges.
module reset_sync #(
  parameter int unsigned Stages = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n_in,
  output logic rst_n_out
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], 1'b1};
    end
  end

  assign rst_n_out = sync_q[Stages-1];

endmodule

// File: rtl/clk_counter_leds_top.sv
// Free-running 32-bit counter whose top byte drives the green LEDs.
// Optional 1 Hz heartbeat on LEDG[7] with CLK_COUNTER_LEDS_HEARTBEAT_EN defined.
module clk_counter_leds_top
  import clk_counter_leds_pkg::*;
#(
  parameter int  EXT_CLOCK_FREQ   = 50000000,
  parameter real EXT_CLOCK_PERIOD = 20.000
) (
  input  logic       EXTCLK,
  input  logic [1:0] KEY_n,
  output logic [7:0] LEDG
);

  localparam real unused_period = EXT_CLOCK_PERIOD;

  logic     rst_n_sync;
  counter_t clk_counter;

  reset_sync #(
    .Stages(RST_SYNC_STAGES)
  ) u_reset_sync (
    .clk      (EXTCLK),
    .rst_n_in (KEY_n[0]),
    .rst_n_out(rst_n_sync)
  );

  always_ff @(posedge EXTCLK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      clk_counter <= '0;
    end else begin
      clk_counter <= clk_counter + counter_t'(1);
    end
  end

`ifdef CLK_COUNTER_LEDS_HEARTBEAT_EN
  localparam int unsigned HB_HALF = (EXT_CLOCK_FREQ / 2 > 0) ? EXT_CLOCK_FREQ / 2 : 1;
  localparam int unsigned HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  logic [HB_W-1:0] heartbeat_cnt;
  logic            heartbeat;

  always_ff @(posedge EXTCLK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      heartbeat_cnt <= '0;
      heartbeat     <= 1'b0;
    end else if (heartbeat_cnt == HB_W'(HB_HALF - 1)) begin
      heartbeat_cnt <= '0;
      heartbeat     <= ~heartbeat;
    end else begin
      heartbeat_cnt <= heartbeat_cnt + HB_W'(1);
    end
  end

  // Holding KEY_n[1] lights LEDG[7] as a button indicator.
  always_comb begin
    LEDG    = led_field(clk_counter);
    LEDG[7] = heartbeat | ~KEY_n[1];
  end
`else
  localparam int unused_freq = EXT_CLOCK_FREQ;
  logic unused_key;

  assign unused_key = KEY_n[1];

  always_comb begin
    LEDG = led_field(clk_counter);
  end
`endif

endmodule

// File: tb/tb_clk_counter_leds_top.sv
// Directed self-checking bench for clk_counter_leds_top.
module tb_clk_counter_leds_top;

  logic        EXTCLK;
  logic [1:0]  KEY_n;
  logic [7:0]  LEDG;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;
  logic [31:0] start_cnt;

`ifdef CLK_COUNTER_LEDS_HEARTBEAT_EN
  localparam logic [7:0] LedMask = 8'h7F;
  int   m_hb_cnt;
  logic m_hb;
`else
  localparam logic [7:0] LedMask = 8'hFF;
`endif

  clk_counter_leds_top #(
    .EXT_CLOCK_FREQ  (20),
    .EXT_CLOCK_PERIOD(20.000)
  ) dut (
    .EXTCLK(EXTCLK),
    .KEY_n (KEY_n),
    .LEDG  (LEDG)
  );

  initial EXTCLK = 1'b0;
  always #10 EXTCLK = ~EXTCLK;

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge EXTCLK);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_led;
    exp_led = exp_cnt[31:24];
    check({tag, "_cnt"}, dut.clk_counter, exp_cnt);
    check({tag, "_led"}, {24'h0, LEDG & LedMask}, {24'h0, exp_led & LedMask});
  endtask

`ifdef CLK_COUNTER_LEDS_HEARTBEAT_EN
  task automatic hb_model_step();
    if (m_hb_cnt == 9) begin
      m_hb_cnt = 0;
      m_hb     = ~m_hb;
    end else begin
      m_hb_cnt++;
    end
  endtask
`endif

  initial begin
    KEY_n   = 2'b11;
    exp_cnt = '0;
    #5 KEY_n = 2'b10;
    repeat (3) step();
    check_state("reset");

    // Release: sync output rises on 2nd edge, counter reads 1 after the 3rd.
    KEY_n = 2'b11;
    step(); check_state("rel1");
    step(); check_state("rel2");
    step(); exp_cnt = 32'd1; check_state("rel3");

    for (int i = 0; i < 20; i++) begin
      step(); exp_cnt++; check_state("run20");
    end

    // Short mid-count reset pulse (50 ns).
    step(); exp_cnt++; check_state("pre_pulse");
    #5 KEY_n[0] = 1'b0;
    #1 exp_cnt = '0; check_state("pulse");
    #49 KEY_n[0] = 1'b1;
    step(); check_state("prel1");
    step(); check_state("prel2");
    step(); check_state("prel3");
    step(); exp_cnt = 32'd1; check_state("prel4");
    for (int i = 0; i < 3; i++) begin
      step(); exp_cnt++; check_state("prun");
    end

    while (exp_cnt < 32'd300) begin
      step(); exp_cnt++; check_state("run300");
      if (exp_cnt == 32'd256) check("hit_100", dut.clk_counter, 32'h0000_0100);
    end

    // KEY_n[1] must not disturb the counter.
    start_cnt = exp_cnt;
    KEY_n[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); exp_cnt++; check_state("key1_low");
    end
    KEY_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); exp_cnt++; check_state("key1_high");
    end
    check("key1_adv", dut.clk_counter - start_cnt, 32'd20);

    // Byte rollover into the LEDs, then full 32-bit wrap.
    force dut.clk_counter = 32'h00FF_FFFF;
    #1 release dut.clk_counter;
    step(); exp_cnt = 32'h0100_0000; check_state("roll24");
    check("led_01", {24'h0, LEDG & LedMask}, 32'h0000_0001);
    force dut.clk_counter = 32'hFFFF_FFFF;
    #1 release dut.clk_counter;
    step(); exp_cnt = 32'h0; check_state("wrap32");
    check("led_00", {24'h0, LEDG}, 32'h0);
    step(); exp_cnt = 32'd1; check_state("post_wrap");

`ifdef CLK_COUNTER_LEDS_HEARTBEAT_EN
    KEY_n[0] = 1'b0;
    #1 check("hb_rst", {31'h0, LEDG[7]}, 32'h0);
    step(); check("hb_rst_hold", {31'h0, LEDG[7]}, 32'h0);
    KEY_n = 2'b11;
    repeat (3) step();
    m_hb_cnt = 1;
    m_hb     = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(); hb_model_step();
      check("hb_toggle", {31'h0, LEDG[7]}, {31'h0, m_hb});
    end
    KEY_n[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); hb_model_step();
      check("hb_key_on", {31'h0, LEDG[7]}, 32'h1);
    end
    KEY_n[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); hb_model_step();
      check("hb_key_off", {31'h0, LEDG[7]}, {31'h0, m_hb});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_counter_leds_top.md
Name: clk_counter_leds_top

Overview:
- Top-level LED demo for the DE0-Nano board.
- A free-running 32-bit counter increments on every rising edge of the 50 MHz board clock.
- The 8 green LEDs display the counter's top byte, so they visibly binary-count at about 3 Hz per LSB.
- KEY_n[0] is the board reset. KEY_n[1] is a user button, reserved and functionally ignored.

Parameters:
- EXT_CLOCK_FREQ, 50000000, board clock frequency in Hz (integer). Used only by the optional feature.
- EXT_CLOCK_PERIOD, 20.000, board clock period in ns (real). Informational/simulation only; no synthesized effect.

Ports:
- EXTCLK  input  1  50 MHz board clock; all logic on its rising edge.
- KEY_n  input  2  active-low push-buttons:
  - [0] is the asynchronous active-low reset.
  - [1] is a user key with no effect on the counter or LEDG.
- LEDG  output  8  green LEDs, active-high.

Behaviour:
- Clock and reset: one clock, EXTCLK. Reset is KEY_n[0], asynchronous and active-low.
- Reset path:
  - KEY_n[0] feeds a 2-flop reset synchronizer producing rst_n_sync.
  - Assertion is asynchronous: rst_n_sync goes 0 immediately when KEY_n[0]=0.
  - Deassertion is synchronous: rst_n_sync goes 1 on the 2nd EXTCLK rising edge after KEY_n[0] returns to 1.
- Counter:
  - Internal register named clk_counter, 32 bits. This name is fixed; benches probe dut.clk_counter hierarchically.
  - While rst_n_sync=0: clk_counter=32'h0, forced asynchronously.
  - Otherwise: clk_counter <= clk_counter+1 on every EXTCLK rising edge. No enable.
  - Wraps 32'hFFFF_FFFF -> 32'h0000_0000 silently, with no flag.
  - First increment occurs on the first rising edge where rst_n_sync is already 1. After release, the counter reads 1 after at most 3 rising edges.
- LEDG:
  - LEDG = clk_counter[31:24], combinational from the register. Zero added latency relative to the counter.
  - Reset value: 8'h00.
  - LEDG[0] toggles every 2^24 cycles (~335.5 ms at 50 MHz). In short simulations (< 2^24 cycles) LEDG remains 8'h00.
- Reset during operation: any low pulse on KEY_n[0], even shorter than one clock, clears clk_counter and LEDG immediately. Counting restarts from 0 after the synchronizer releases.
- KEY_n[1]: ignored. Toggling it leaves clk_counter and LEDG trajectory unchanged. It is read only by the optional feature.
- Power-up: no initial values are relied upon; behaviour is defined after the first reset. If a simulator starts without reset, the counter is X until reset.

Optional Feature:
- Macro: CLK_COUNTER_LEDS_HEARTBEAT_EN.
- Defined:
  - A second counter, heartbeat_cnt, counts 0..EXT_CLOCK_FREQ/2-1 and toggles a heartbeat bit at wrap, giving a 1 Hz square wave.
  - LEDG[7] = heartbeat; LEDG[6:0] = clk_counter[30:24].
  - While KEY_n[1]=0, the heartbeat is forced to 1 (LED on) as a button indicator.
  - Reset clears heartbeat_cnt and heartbeat to 0.
- Undefined: LEDG = clk_counter[31:24] exactly as above. No heartbeat logic; KEY_n[1] fully unused.

Decomposition:
- Package clk_counter_leds_pkg holds:
  - localparams COUNTER_W=32, LED_W=8, LED_LSB=COUNTER_W-LED_W (24), RST_SYNC_STAGES=2;
  - typedef logic [COUNTER_W-1:0] counter_t;
  - typedef logic [LED_W-1:0] leds_t.
- One sub-module: reset_sync. Parameterized by stage count; async-assert/sync-deassert active-low reset synchronizer; ports clk, rst_n_in, rst_n_out.
- Counter and LED mapping stay in the top.

Test Plan:
- Power-up with KEY_n=2'b11 after an initial reset pulse, run 20 cycles -> clk_counter increments by exactly 1 per edge; clk_counter[31:24]=8'h00; LEDG=8'b00000000.
- KEY_n[0]=0 for 50 ns mid-count -> clk_counter=0 and LEDG=0 within the same timestep. Release -> counter is 1 no later than the 3rd rising edge and increments each cycle thereafter.
- Run 300 cycles after reset -> clk_counter reaches 32'h100 at the 256th increment; LEDG stays 8'h00.
- Force clk_counter to 32'h00FF_FFFF, then 1 clock -> LEDG=8'h01. Force 32'hFFFF_FFFF, then 1 clock -> clk_counter=0, LEDG=8'h00.
- KEY_n[1]=0 for 10 cycles, then 1 for 10 cycles (macro undefined) -> clk_counter advances by exactly 20 and LEDG matches clk_counter[31:24] throughout.
- Macro defined, EXT_CLOCK_FREQ=20, checks:
  - LEDG[7] toggles every 10 cycles;
  - KEY_n[1]=0 holds LEDG[7]=1;
  - reset clears LEDG[7] to 0.
